// File: rtl/sevenseg_scan.sv
// Time-multiplexed common-anode seven-segment scanner with a frame-synchronous
// pending->display commit, dead-time between digits and leading-zero blanking.
module sevenseg_scan #(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned DEAD        = 16,
   parameter bit          LZ_BLANK    = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [4*NUM_DIGITS-1:0] wr_data,
   input  logic [NUM_DIGITS-1:0]   wr_dp,
   input  logic                    blank,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame_done
);

   localparam int unsigned TW = $clog2(REFRESH_DIV);
   localparam int unsigned IW = $clog2(NUM_DIGITS);

   logic [TW-1:0]           tick_q, tick_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic                    pend_full_q, pend_full_d;
   logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
   logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
   logic [4*NUM_DIGITS-1:0] disp_data_q, disp_data_d;
   logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic                    frame_done_q, frame_done_d;

   logic                    tick_end, idx_end, boundary, accept;
   logic                    zero_above;
   logic [NUM_DIGITS-1:0]   lz_dark;
   logic [3:0]              cur_nib;
   logic                    cur_dp, cur_dark;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      unique case (h)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         4'hF: s = 7'b0111000;
      endcase
      return s;
   endfunction

   always_comb begin
      tick_end = (tick_q == TW'(REFRESH_DIV - 1));
      idx_end  = (idx_q == IW'(NUM_DIGITS - 1));
      boundary = tick_end && idx_end;
      accept   = wr_valid && !pend_full_q;

      tick_d = tick_end ? '0 : tick_q + TW'(1);
      idx_d  = idx_q;
      if (tick_end) idx_d = idx_end ? '0 : idx_q + IW'(1);

      pend_full_d = pend_full_q;
      pend_data_d = pend_data_q;
      pend_dp_d   = pend_dp_q;
      disp_data_d = disp_data_q;
      disp_dp_d   = disp_dp_q;
      // accept needs an empty pending slot and commit needs a full one: never both
      if (accept) begin
         pend_full_d = 1'b1;
         pend_data_d = wr_data;
         pend_dp_d   = wr_dp;
      end else if (boundary && pend_full_q) begin
         pend_full_d = 1'b0;
         disp_data_d = pend_data_q;
         disp_dp_d   = pend_dp_q;
      end

      // A digit goes dark when it and everything above it is zero with no dp lit
      zero_above = 1'b1;
      lz_dark    = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above && (disp_data_q[4*i +: 4] == 4'h0) && !disp_dp_q[i];
         lz_dark[i] = LZ_BLANK && (i != 0) && zero_above;
      end

      cur_nib  = '0;
      cur_dp   = 1'b0;
      cur_dark = 1'b0;
      an_d     = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (IW'(i) == idx_q) begin
            cur_nib  = disp_data_q[4*i +: 4];
            cur_dp   = disp_dp_q[i];
            cur_dark = lz_dark[i];
            an_d[i]  = 1'b0;
         end
      end

      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if (blank || (tick_q < TW'(DEAD))) begin
         an_d = '1;
      end else if (!cur_dark) begin
         seg_d = hex_to_seg(cur_nib);
         dp_d  = ~cur_dp;
      end

      frame_done_d = boundary;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_q       <= '0;
         idx_q        <= '0;
         pend_full_q  <= 1'b0;
         pend_data_q  <= '0;
         pend_dp_q    <= '0;
         disp_data_q  <= '0;
         disp_dp_q    <= '0;
         an_q         <= '1;
         seg_q        <= 7'h7F;
         dp_q         <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         tick_q       <= tick_d;
         idx_q        <= idx_d;
         pend_full_q  <= pend_full_d;
         pend_data_q  <= pend_data_d;
         pend_dp_q    <= pend_dp_d;
         disp_data_q  <= disp_data_d;
         disp_dp_q    <= disp_dp_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign wr_ready   = ~pend_full_q;
   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_done = frame_done_q;

endmodule

// File: doc/sevenseg_scan.md
Name: sevenseg_scan

Overview:
Time-multiplexed controller for a NUM_DIGITS-digit common-anode seven-segment display. It accepts a hex value from the CPU/debug side through a valid/ready handshake and holds it in a pending register. The value moves to the display register only at a frame boundary, so a frame never shows a mix of old and new digits. It scans the digits at a fixed rate, with a dead-time gap against ghosting, optional leading-zero blanking and per-digit decimal points.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
REFRESH_DIV, 50000, clock cycles per digit slot (>= DEAD+2)
DEAD, 16, cycles at slot start with all anodes off
LZ_BLANK, 1, 1 = blank leading zero digits; digit 0 is never blanked

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  new value offered
wr_ready  out  1  block can accept a value
wr_data  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i (digit 0 = rightmost)
wr_dp  in  NUM_DIGITS  decimal-point enables, bit i = digit i
blank  in  1  force display dark (level, sampled every cycle)
an  out  NUM_DIGITS  digit enables, active-low, one-cold
seg  out  7  segments {a,b,c,d,e,f,g}, active-low
dp  out  1  decimal point, active-low
frame_done  out  1  one-cycle pulse at end of each full scan

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n). All state is cleared on rst_n low, regardless of clock.
- Reset values:
  - an = all 1s, seg = 7'h7F, dp = 1, frame_done = 0, wr_ready = 1.
  - tick counter = 0, digit index = 0, pending_full = 0.
  - display and pending data/dp = 0.
- Tick counter runs 0..REFRESH_DIV-1. At REFRESH_DIV-1 it returns to 0 and the digit index advances. The index wraps from NUM_DIGITS-1 to 0.
- Frame boundary = cycle where tick = REFRESH_DIV-1 and index = NUM_DIGITS-1. frame_done is registered and is high in the cycle after the boundary, for one cycle.
- Handshake:
  - A transfer occurs when wr_valid and wr_ready are both high on a clock edge. wr_data/wr_dp go to the pending register and pending_full is set.
  - wr_ready = !pending_full (registered).
  - At a frame boundary with pending_full = 1: pending moves to the display register, pending_full clears, and wr_ready is 1 the following cycle.
  - A transfer in the same cycle as a boundary while pending_full = 0 is captured in pending. It commits at the next boundary, not the current one.
  - wr_valid while wr_ready = 0 is ignored; the producer holds the value.
- Segment encoding (active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111.
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Output per slot (registered, one-cycle latency from tick/index):
  - tick < DEAD: an all 1s, seg 7'h7F, dp 1.
  - Otherwise: an[index] = 0, all other an bits = 1; seg = encoding of display nibble[index]; dp = ~display_dp[index].
- Leading-zero blanking (LZ_BLANK=1): digit i > 0 is blanked when nibbles i..NUM_DIGITS-1 are all zero and dp bits i..NUM_DIGITS-1 are all zero. A blanked digit has its anode still driven, seg = 7'h7F, dp = 1.
- blank = 1 forces an all 1s from the next cycle. Counters and the handshake keep running, and commits still happen.
- Reset mid-frame: scan restarts at digit 0, tick 0. The pending value is discarded and the display reads 0.

Test Plan:
- Sim params NUM_DIGITS=4, REFRESH_DIV=8, DEAD=2 for all scenarios.
- Reset then run 64 cycles, LZ_BLANK=1, value 0: only digit 0 lit, an=1110 with seg=0000001. an=1111 in cycles 0-1 of every slot. frame_done pulses every 32 cycles.
- Write 16'h12AF, dp=0 mid-frame: wr_ready drops the cycle after accept. The display keeps the old value until the boundary, then shows F,A,2,1 on digits 0..3 with seg 0111000/0001000/0010010/1001111. wr_ready is 1 after the boundary.
- Write 16'h0050, dp=0000: digits 3 and 2 are dark (seg 7F with anode driven). Digit 1 = 0100100, digit 0 = 0000001. Repeat with dp=1000: all digits lit and dp=0 on digit 3 only.
- Hold wr_valid with two values back-to-back: the second is accepted only after the first commits. The second appears exactly one frame (32 cycles) later. Also cover a write landing on the boundary cycle, which commits one frame late.
- Assert blank for 20 cycles mid-slot: an=1111 throughout. frame_done timing is unchanged. Deassert, and the scan resumes at the current index.
- Drop rst_n asynchronously between clock edges mid-frame with a pending write: outputs go to reset values immediately. After release the pending value is lost and digit 0 shows 0.
